dmem_arbiter: RTL

Shares the single data-memory port between three line-granular requesters: instruction-cache refill, data-cache refill/writeback, and victim-cache writeback. It grants exactly one requester per transaction and holds that grant until memory acknowledges the transaction or the data cache kills it. Memory signals pass through from the granted requester to the memory port. It sits between the cache controllers and the memory bus wrapper.

---
 rtl/dmem_arbiter.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares the single line-granular data-memory port between the instruction
//   cache refill path, the data cache refill/writeback path and the victim
//   cache writeback path. One requester is granted per transaction. The grant
//   is held until memory acknowledges the transaction, or until the data cache
//   kills its own request.
//
// Ports
//   clk, rst_n                   clock, asynchronous active-low reset
//   icache_req/addr/ack          icache line read (never a write)
//   dcache_req/wr/addr/wdata     dcache refill (wr=0) or writeback (wr=1)
//   dcache_kill, dcache_ack      dcache abort and completion
//   victim_req/addr/wdata/ack    victim line writeback (always a write)
//   mem_req/wr/addr/wdata        memory request, driven from registered values
//   mem_kill                     one-cycle abort of the outstanding request
//   mem_ack, mem_rdata (in)      memory completion and read line
//   mem_rdata_o                  read line broadcast to every requester
//   busy_o                       a transaction is outstanding
module dmem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  icache_req_i,
    input  logic [ADDR_WIDTH-1:0] icache_addr_i,
    output logic                  icache_ack_o,
    input  logic                  dcache_req_i,
    input  logic                  dcache_wr_i,
    input  logic [ADDR_WIDTH-1:0] dcache_addr_i,
    input  logic [LINE_WIDTH-1:0] dcache_wdata_i,
    input  logic                  dcache_kill_i,
    output logic                  dcache_ack_o,
    input  logic                  victim_req_i,
    input  logic [ADDR_WIDTH-1:0] victim_addr_i,
    input  logic [LINE_WIDTH-1:0] victim_wdata_i,
    output logic                  victim_ack_o,
    output logic                  mem_req_o,
    output logic                  mem_wr_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [LINE_WIDTH-1:0] mem_wdata_o,
    output logic                  mem_kill_o,
    input  logic                  mem_ack_i,
    input  logic [LINE_WIDTH-1:0] mem_rdata_i,
    output logic [LINE_WIDTH-1:0] mem_rdata_o,
    output logic                  busy_o
);

    localparam logic [0:0] ARB_IDLE = 1'b0;
    localparam logic [0:0] ARB_BUSY = 1'b1;

    localparam logic [1:0] GNT_NONE   = 2'd0;
    localparam logic [1:0] GNT_ICACHE = 2'd1;
    localparam logic [1:0] GNT_DCACHE = 2'd2;
    localparam logic [1:0] GNT_VICTIM = 2'd3;

    logic [0:0]            state;
    logic [1:0]            grant;
    logic [1:0]            rr_last;
    logic                  wr_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LINE_WIDTH-1:0] wdata_q;

    logic                  dcache_eligible;
    logic [1:0]            winner;
    logic                  sel_wr;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [LINE_WIDTH-1:0] sel_wdata;
    logic                  busy;
    logic                  ack;
    logic                  kill;

    // A dcache request that is being killed in the same cycle is not a
    // candidate, so a kill can never start a transaction.
    assign dcache_eligible = dcache_req_i & ~dcache_kill_i;

    // Victim has fixed top priority; icache/dcache share round-robin where
    // the requester that did not win last time takes a tie.
    always_comb begin
        winner = GNT_NONE;
        if (victim_req_i) begin
            winner = GNT_VICTIM;
        end else if (icache_req_i && dcache_eligible) begin
            winner = (rr_last == GNT_ICACHE) ? GNT_DCACHE : GNT_ICACHE;
        end else if (icache_req_i) begin
            winner = GNT_ICACHE;
        end else if (dcache_eligible) begin
            winner = GNT_DCACHE;
        end
    end

    always_comb begin
        sel_wr    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        case (winner)
            GNT_VICTIM: begin
                sel_wr    = 1'b1;
                sel_addr  = victim_addr_i;
                sel_wdata = victim_wdata_i;
            end
            GNT_DCACHE: begin
                sel_wr    = dcache_wr_i;
                sel_addr  = dcache_addr_i;
                sel_wdata = dcache_wdata_i;
            end
            GNT_ICACHE: begin
                sel_addr  = icache_addr_i;
            end
            default: ;
        endcase
    end

    assign busy = (state == ARB_BUSY);
    assign ack  = busy & mem_ack_i;
    // An ack in the same cycle beats a kill: the transaction already finished.
    assign kill = busy & (grant == GNT_DCACHE) & dcache_kill_i & ~mem_ack_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ARB_IDLE;
            grant   <= GNT_NONE;
            rr_last <= GNT_ICACHE;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (state == ARB_IDLE) begin
            if (winner != GNT_NONE) begin
                state   <= ARB_BUSY;
                grant   <= winner;
                wr_q    <= sel_wr;
                addr_q  <= sel_addr;
                wdata_q <= sel_wdata;
                // Victim grants leave the icache/dcache rotation untouched.
                if (winner != GNT_VICTIM) begin
                    rr_last <= winner;
                end
            end
        end else begin
            if (ack || kill) begin
                state <= ARB_IDLE;
                grant <= GNT_NONE;
            end
        end
    end

    assign busy_o       = busy;
    assign mem_req_o    = busy & ~kill;
    assign mem_wr_o     = busy & wr_q;
    assign mem_addr_o   = busy ? addr_q : '0;
    assign mem_wdata_o  = busy ? wdata_q : '0;
    assign mem_kill_o   = kill;
    assign icache_ack_o = ack & (grant == GNT_ICACHE);
    assign dcache_ack_o = ack & (grant == GNT_DCACHE);
    assign victim_ack_o = ack & (grant == GNT_VICTIM);
    assign mem_rdata_o  = mem_rdata_i;

endmodule
